// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with exception redirect.
// Ports: clk, rst (sync, active-high), stallreq_from_id/ex/mem,
//   excepttype_i, cp0_epc_i -> stall[5:0], flush, new_pc,
//   stall_cycles_o, wdt_timeout_o.
// Optional stall watchdog: define PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [15:0] WDT_LIMIT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o,
  output logic        wdt_timeout_o
);

  localparam logic [31:0] ERET = 32'h0000000e;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RECOVER
  } state_t;

  state_t      state;
  logic        exc;
  logic [5:0]  req_stall;
  logic [31:0] cyc_q;

  assign exc = |excepttype_i;
  assign stall_cycles_o = cyc_q;

  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_from_mem)
      req_stall = 6'b011111;
    else if (stallreq_from_ex)
      req_stall = 6'b001111;
    else if (stallreq_from_id)
      req_stall = 6'b000111;
  end

  // Exception redirect only from IDLE; FLUSH holds
  // everything quiet for one cycle.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (exc) begin
            flush  = 1'b1;
            new_pc = (excepttype_i == ERET) ?
                     cp0_epc_i : EXC_VECTOR;
          end else begin
            stall = req_stall;
          end
        end
        RECOVER: stall = req_stall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE:    if (exc) state <= FLUSH;
        FLUSH:   state <= RECOVER;
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (stall[0])
        cyc_q <= cyc_q + 32'd1;
    end
  end

`ifdef PIPE_CTRL_STALL_WDT_EN
  logic [15:0] run_q;
  logic [15:0] run_nxt;
  logic        wdt_q;

  // Flush implies stall[0]=0, so the run also
  // clears on every flush cycle.
  always_comb begin
    run_nxt = 16'h0;
    if (stall[0])
      run_nxt = (run_q == 16'hFFFF) ?
                run_q : run_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 16'h0;
      wdt_q <= 1'b0;
    end else begin
      run_q <= run_nxt;
      if (stall[0] && run_nxt == WDT_LIMIT)
        wdt_q <= 1'b1;
    end
  end

  assign wdt_timeout_o = wdt_q;
`else
  wire unused_wdt = ^WDT_LIMIT;
  assign wdt_timeout_o = 1'b0;
`endif

endmodule
